// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline hazard bus between the core datapath (master) and the sequencer (slave)
interface hazard_ctrl_if;
    logic [4:0]  Rs1D, Rs2D, rs1_addr_E, rs2_addr_E, RdE, RdM, RdW;
    logic [1:0]  ResultSrcE;
    logic        RegWriteM, RegWriteW;
    logic        BranchE, JumpE, jalrE, BranchTakenE, Predict_branchE;
    logic        MemReqM, DmemReadyM;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        RedirectE, RedirectSelE;
    logic        BpUpdateEn, BpUpdateTaken;
    logic        MemErr;
    logic [31:0] MispredCnt, StallCnt;

    modport master (
        output Rs1D, Rs2D, rs1_addr_E, rs2_addr_E, RdE, RdM, RdW, ResultSrcE, RegWriteM, RegWriteW,
               BranchE, JumpE, jalrE, BranchTakenE, Predict_branchE, MemReqM, DmemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE,
               RedirectE, RedirectSelE, BpUpdateEn, BpUpdateTaken, MemErr, MispredCnt, StallCnt
    );

    modport slave (
        input  Rs1D, Rs2D, rs1_addr_E, rs2_addr_E, RdE, RdM, RdW, ResultSrcE, RegWriteM, RegWriteW,
               BranchE, JumpE, jalrE, BranchTakenE, Predict_branchE, MemReqM, DmemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE,
               RedirectE, RedirectSelE, BpUpdateEn, BpUpdateTaken, MemErr, MispredCnt, StallCnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline stall/flush/forward/redirect sequencer with memory-wait watchdog; optional perf counters via HAZ_PERF_CNT_EN
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_mem_err, w_err_set;
    logic          w_timeout, w_memstall, w_mis, w_lu, w_live;

    assign w_live     = rst;
    assign w_timeout  = (r_state == MEM_WAIT) && (r_cnt == CW'(MEM_TIMEOUT));
    assign w_memstall = bus.MemReqM & ~bus.DmemReadyM & ~w_timeout;
    assign w_mis      = (bus.BranchE & (bus.BranchTakenE ^ bus.Predict_branchE))
                      | (bus.JumpE & ~bus.Predict_branchE) | bus.jalrE;
    assign w_lu       = (bus.ResultSrcE == 2'b01) && (bus.RdE != 5'd0)
                      && ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

    // Memory wait sequencing: enter on an unfinished access, leave on ready or watchdog expiry
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_set   = 1'b0;
        if (r_state == RUN) begin
            if (bus.MemReqM && !bus.DmemReadyM) begin
                w_state_nxt = MEM_WAIT;
                w_cnt_nxt   = CW'(1);
            end
        end else if (bus.DmemReadyM) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
        end else if (w_timeout) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
            w_err_set   = 1'b1;
        end else begin
            w_cnt_nxt   = r_cnt + CW'(1);
        end
    end

    // State, wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_mem_err <= r_mem_err | w_err_set;
        end
    end

    // Forwarding selects: M result beats W result; x0 is never forwarded
    always_comb begin
        bus.ForwardAE = 2'b00;
        bus.ForwardBE = 2'b00;
        if (w_live) begin
            bus.ForwardAE = (bus.RegWriteM && bus.RdM != 5'd0 && bus.RdM == bus.rs1_addr_E) ? 2'b10 :
                            (bus.RegWriteW && bus.RdW != 5'd0 && bus.RdW == bus.rs1_addr_E) ? 2'b01 : 2'b00;
            bus.ForwardBE = (bus.RegWriteM && bus.RdM != 5'd0 && bus.RdM == bus.rs2_addr_E) ? 2'b10 :
                            (bus.RegWriteW && bus.RdW != 5'd0 && bus.RdW == bus.rs2_addr_E) ? 2'b01 : 2'b00;
        end
    end

    // Memory stall defers everything; a mispredict squashes D so it overrides load-use
    assign bus.StallF        = w_live & (w_memstall | (w_lu & ~w_mis));
    assign bus.StallD        = w_live & (w_memstall | (w_lu & ~w_mis));
    assign bus.StallE        = w_live & w_memstall;
    assign bus.StallM        = w_live & w_memstall;
    assign bus.FlushD        = ~w_live | (~w_memstall & w_mis);
    assign bus.FlushE        = ~w_live | (~w_memstall & (w_mis | w_lu));
    assign bus.FlushW        = ~w_live | w_memstall;
    assign bus.RedirectE     = w_live & ~w_memstall & w_mis;
    assign bus.RedirectSelE  = bus.jalrE | bus.JumpE | bus.BranchTakenE;
    assign bus.BpUpdateEn    = w_live & bus.BranchE & ~w_memstall;
    assign bus.BpUpdateTaken = bus.BranchTakenE;
    assign bus.MemErr        = r_mem_err;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_mis_cnt, r_stall_cnt;

    // Wrapping counts of redirect cycles and memory-stall cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mis_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_mis_cnt   <= r_mis_cnt + {31'd0, bus.RedirectE};
            r_stall_cnt <= r_stall_cnt + {31'd0, w_memstall};
        end
    end

    assign bus.MispredCnt = r_mis_cnt;
    assign bus.StallCnt   = r_stall_cnt;
`else
    assign bus.MispredCnt = 32'd0;
    assign bus.StallCnt   = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a cycle-level reference model
module tb_hazard_ctrl;
    localparam int T = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    int          m_waited;
    bit          m_err;
    logic [31:0] m_mis_cnt, m_stall_cnt;

    hazard_ctrl_if bus ();

    hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (bus.RegWriteM && bus.RdM != 0 && bus.RdM == rs) return 2'b10;
        if (bus.RegWriteW && bus.RdW != 0 && bus.RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle();
        bus.Rs1D = 0; bus.Rs2D = 0; bus.rs1_addr_E = 0; bus.rs2_addr_E = 0;
        bus.RdE = 0; bus.RdM = 0; bus.RdW = 0; bus.ResultSrcE = 0;
        bus.RegWriteM = 0; bus.RegWriteW = 0; bus.BranchE = 0; bus.JumpE = 0; bus.jalrE = 0;
        bus.BranchTakenE = 0; bus.Predict_branchE = 0; bus.MemReqM = 0; bus.DmemReadyM = 1;
    endtask

    // Inputs are applied at the falling edge; outputs are checked 1 time unit later; model advances at the rising edge
    task automatic step();
        bit ms, mis, lu, live, redir;
        #1;
        live = rst;
        if (!live) begin
            m_waited = 0; m_err = 0; m_mis_cnt = 0; m_stall_cnt = 0;
        end
        ms    = live && bus.MemReqM && !bus.DmemReadyM && !(m_waited == T);
        mis   = (bus.BranchE && (bus.BranchTakenE != bus.Predict_branchE))
             || (bus.JumpE && !bus.Predict_branchE) || bus.jalrE;
        lu    = bus.ResultSrcE == 2'b01 && bus.RdE != 0 && (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
        redir = live && !ms && mis;
        chk("StallF", bus.StallF, live && (ms || (lu && !mis)));
        chk("StallD", bus.StallD, live && (ms || (lu && !mis)));
        chk("StallE", bus.StallE, ms);
        chk("StallM", bus.StallM, ms);
        chk("FlushD", bus.FlushD, !live || redir);
        chk("FlushE", bus.FlushE, !live || (!ms && (mis || lu)));
        chk("FlushW", bus.FlushW, !live || ms);
        chk("ForwardAE", bus.ForwardAE, live ? fwd(bus.rs1_addr_E) : 2'b00);
        chk("ForwardBE", bus.ForwardBE, live ? fwd(bus.rs2_addr_E) : 2'b00);
        chk("RedirectE", bus.RedirectE, redir);
        chk("RedirectSelE", bus.RedirectSelE, bus.jalrE || bus.JumpE || bus.BranchTakenE);
        chk("BpUpdateEn", bus.BpUpdateEn, live && bus.BranchE && !ms);
        chk("BpUpdateTaken", bus.BpUpdateTaken, bus.BranchTakenE);
        chk("MemErr", bus.MemErr, m_err);
`ifdef HAZ_PERF_CNT_EN
        chk("MispredCnt", bus.MispredCnt, m_mis_cnt);
        chk("StallCnt", bus.StallCnt, m_stall_cnt);
`else
        chk("MispredCnt", bus.MispredCnt, 32'd0);
        chk("StallCnt", bus.StallCnt, 32'd0);
`endif
        @(posedge clk);
        if (live) begin
            m_mis_cnt   += redir ? 1 : 0;
            m_stall_cnt += ms ? 1 : 0;
            if (m_waited == 0) m_waited = (bus.MemReqM && !bus.DmemReadyM) ? 1 : 0;
            else if (bus.DmemReadyM) m_waited = 0;
            else if (m_waited == T) begin m_waited = 0; m_err = 1; end
            else m_waited++;
        end
        @(negedge clk);
    endtask

    initial begin
        m_waited = 0; m_err = 0; m_mis_cnt = 0; m_stall_cnt = 0;
        idle();
        step();
        step();
        rst = 1'b1;
        step();
        bus.ResultSrcE = 2'b01; bus.RdE = 5; bus.Rs2D = 5;
        step();
        bus.RdE = 0; bus.Rs2D = 0;
        step();
        idle();
        bus.BranchE = 1; bus.Predict_branchE = 1; bus.BranchTakenE = 0;
        step();
        idle();
        bus.RdM = 7; bus.RdW = 7; bus.RegWriteM = 1; bus.RegWriteW = 1; bus.rs1_addr_E = 7; bus.rs2_addr_E = 7;
        step();
        bus.RegWriteM = 0;
        step();
        bus.RdM = 0; bus.RdW = 0; bus.RegWriteM = 1;
        step();
        idle();
        bus.MemReqM = 1; bus.DmemReadyM = 0; bus.BranchE = 1; bus.Predict_branchE = 1;
        repeat (3) step();
        bus.DmemReadyM = 1;
        step();
        idle();
        bus.MemReqM = 1; bus.DmemReadyM = 0;
        repeat (5) step();
        idle();
        step();
        bus.MemReqM = 1; bus.DmemReadyM = 0;
        repeat (2) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        idle();
        step();
        for (int i = 0; i < 600; i++) begin
            bus.Rs1D = 5'($urandom_range(0, 3)); bus.Rs2D = 5'($urandom_range(0, 3));
            bus.rs1_addr_E = 5'($urandom_range(0, 3)); bus.rs2_addr_E = 5'($urandom_range(0, 3));
            bus.RdE = 5'($urandom_range(0, 3)); bus.RdM = 5'($urandom_range(0, 3)); bus.RdW = 5'($urandom_range(0, 3));
            bus.ResultSrcE = 2'($urandom_range(0, 3));
            bus.RegWriteM = 1'($urandom); bus.RegWriteW = 1'($urandom);
            bus.BranchE = $urandom_range(0, 2) == 0; bus.JumpE = $urandom_range(0, 5) == 0;
            bus.jalrE = $urandom_range(0, 7) == 0;
            bus.BranchTakenE = 1'($urandom); bus.Predict_branchE = 1'($urandom);
            bus.MemReqM = $urandom_range(0, 2) != 0;
            bus.DmemReadyM = (i % 100 < 50) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0);
            rst = $urandom_range(0, 60) != 0;
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
